ublaze_trans_engine: RTL

UBLAZE_TRANS_ENGINE -- requirements
Module: ublaze_trans_engine

---
 rtl/ublaze_trans_pkg.sv | 35 +++
 rtl/ublaze_trans_fifo.sv | 69 ++++++
 rtl/ublaze_trans_engine.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ublaze_trans_pkg.sv
// rtl/ublaze_trans_pkg.sv - shared types for the transaction engine
//
// Purpose: transaction kind, engine FSM state and the command record
// carried through the command queue.
// Ports: none (package).
// Optional feature macro used by the engine: UBLAZE_TRANS_ENGINE_TIMEOUT_EN.

package ublaze_trans_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } trans_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  // Default field widths of the command record. The engine re-declares the
  // same field layout against its own parameters so widths follow overrides.
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 8;

  typedef struct packed {
    trans_t                    trans;
    logic [DEF_IDX_W-1:0]      idx;
    logic [DEF_ADDR_W-1:0]     addr;
    logic [DEF_DATA_W/8-1:0]   be;
    logic [DEF_DATA_W-1:0]     data;
  } cmd_t;

endpackage

// File: rtl/ublaze_trans_fifo.sv
// rtl/ublaze_trans_fifo.sv - synchronous command FIFO with occupancy output
//
// Purpose: DEPTH-entry first-word-fall-through queue (rdata shows the head).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, wdata     write one entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   rdata           current head entry
//   level           number of stored entries, 0..DEPTH

module ublaze_trans_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    do_push  = push && (level_q != LVL_W'(DEPTH));
    do_pop   = pop && (level_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/ublaze_trans_engine.sv
// rtl/ublaze_trans_engine.sv - queued single-outstanding bus transaction engine
//
// Purpose: accepts READ/WRITE commands into a DEPTH-entry queue, issues them
// one at a time as bus requests and returns one in-order response each.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_*          command handshake and fields
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata                   registered bus request
//   bus_ack, bus_rdata                  bus completion
//   rsp_valid/rsp_ready, rsp_*          response handshake and fields
//   level                               command queue occupancy
// Optional feature: define UBLAZE_TRANS_ENGINE_TIMEOUT_EN to enable the ack
// watchdog (TIMEOUT cycles in REQ) that completes the transaction with rsp_err.

module ublaze_trans_engine
  import ublaze_trans_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_trans,
  input  logic [IDX_W-1:0]             cmd_idx,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W/8-1:0]          cmd_be,
  input  logic [DATA_W-1:0]            cmd_wdata,
  output logic                         bus_req,
  output logic                         bus_we,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [DATA_W/8-1:0]          bus_be,
  output logic [DATA_W-1:0]            bus_wdata,
  input  logic                         bus_ack,
  input  logic [DATA_W-1:0]            bus_rdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_trans,
  output logic [IDX_W-1:0]             rsp_idx,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LVL_W = $clog2(DEPTH+1);

  // Same layout as ublaze_trans_pkg::cmd_t, sized by this instance.
  typedef struct packed {
    trans_t              trans;
    logic [IDX_W-1:0]    idx;
    logic [ADDR_W-1:0]   addr;
    logic [BE_W-1:0]     be;
    logic [DATA_W-1:0]   data;
  } cmd_p_t;

  localparam int CMD_W = $bits(cmd_p_t);

  cmd_p_t            in_cmd, head;
  logic [CMD_W-1:0]  fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              push, pop;

  state_t            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [BE_W-1:0]   bus_be_q, bus_be_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_trans_q, rsp_trans_d;
  logic [IDX_W-1:0]  rsp_idx_q, rsp_idx_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef UBLAZE_TRANS_ENGINE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT+1);
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  // Ready only looks at the stored level: a full queue does not take a
  // command even on the edge that pops the head.
  assign cmd_ready = (fifo_level != LVL_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  assign in_cmd = '{trans: trans_t'(cmd_trans), idx: cmd_idx, addr: cmd_addr,
                    be: cmd_be, data: cmd_wdata};
  assign head   = cmd_p_t'(fifo_rdata);

  ublaze_trans_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_cmd),
    .pop   (pop),
    .rdata (fifo_rdata),
    .level (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    cur_idx_d   = cur_idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_trans_d = rsp_trans_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
`ifdef UBLAZE_TRANS_ENGINE_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (fifo_level != '0) pop = 1'b1;
      end
      REQ: begin
        if (bus_ack) begin
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_trans_d = bus_we_q;
          rsp_idx_d   = cur_idx_q;
          rsp_rdata_d = bus_we_q ? '0 : bus_rdata;
`ifdef UBLAZE_TRANS_ENGINE_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = RSP;
        end
`ifdef UBLAZE_TRANS_ENGINE_TIMEOUT_EN
        // Counter value N means N cycles already spent in REQ; this is the
        // TIMEOUT-th cycle without an ack.
        else if (tmo_cnt_q == CNT_W'(TIMEOUT-1)) begin
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_trans_d = bus_we_q;
          rsp_idx_d   = cur_idx_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RSP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (fifo_level != '0) pop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Popping the head always starts a new bus cycle, from IDLE or straight
    // out of RSP.
    if (pop) begin
      state_d     = REQ;
      bus_req_d   = 1'b1;
      bus_we_d    = (head.trans == WRITE);
      bus_addr_d  = head.addr;
      bus_be_d    = head.be;
      bus_wdata_d = head.data;
      cur_idx_d   = head.idx;
`ifdef UBLAZE_TRANS_ENGINE_TIMEOUT_EN
      tmo_cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      cur_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_trans_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      cur_idx_q   <= cur_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_trans_q <= rsp_trans_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef UBLAZE_TRANS_ENGINE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_trans = rsp_trans_q;
  assign rsp_idx   = rsp_idx_q;
  assign rsp_rdata = rsp_rdata_q;
  assign level     = fifo_level;

endmodule
